memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Two-requester round-robin arbiter/sequencer in front of the single-port Memory block.
//  Port 0 is instruction fetch and port 1 is data load/store.
//  Accepts one request at a time, drives Memory (MemRead/MemWrite/Address/writeData).
//  Returns ReadData, or a write acknowledge, to the requester that issued the request.
//  Sits between the core pipeline and Memory; only one access is in flight at a time.
// PARAMETERS
//  DATA_WIDTH    32  width of writeData/ReadData and requester data buses
//  ADDR_WIDTH    32  width of Address and requester address buses (byte address, passed unmodified)
//  READ_LATENCY  1   cycles from the MemRead cycle until Memory ReadData is valid; legal range 1..15
// PORTS
//  clock       in   1           rising-edge clock
//  reset       in   1           synchronous, active-high reset
//  req_valid   in   2           per-port request valid; bit i = port i
//  req_write   in   2           per-port: 1 = write, 0 = read
//  req_addr0   in   ADDR_WIDTH  port 0 address
//  req_addr1   in   ADDR_WIDTH  port 1 address
//  req_wdata0  in   DATA_WIDTH  port 0 write data
//  req_wdata1  in   DATA_WIDTH  port 1 write data
//  req_ready   out  2           one-hot accept; a request transfers when valid[i] & ready[i]
//  resp_valid  out  2           one-hot, 1-cycle response strobe to the issuing port
//  resp_rdata  out  DATA_WIDTH  read data (0 for writes); valid while resp_valid != 0
//  MemRead     out  1           to Memory
//  MemWrite    out  1           to Memory
//  Address     out  ADDR_WIDTH  to Memory
//  writeData   out  DATA_WIDTH  to Memory
//  ReadData    in   DATA_WIDTH  from Memory
// BEHAVIOUR
//  Reset values
//   - All outputs 0.
//   - FSM = IDLE; last_grant = 1, so port 0 wins the first contention.
//   - Latency counter = 0.
//  FSM: IDLE -> ISSUE -> (read: WAIT -> RESP | write: RESP) -> IDLE
//  IDLE
//   - req_ready is combinational from req_valid, and is asserted only in IDLE.
//   - One valid port: that port is granted.
//   - Both ports valid: the port != last_grant is granted.
//   - On accept: latch write/addr/wdata and the port id, update last_grant, go to ISSUE.
//  ISSUE (exactly 1 cycle)
//   - Registered outputs: Address and writeData = latched values.
//   - MemWrite = 1 for a write; MemRead = 1 for a read.
//   - Write: go to RESP. Read: load counter = READ_LATENCY-1, go to WAIT.
//  WAIT
//   - MemRead and MemWrite = 0; Address held.
//   - Counter decrements each cycle.
//   - When counter == 0: capture ReadData into resp_rdata at that edge, go to RESP.
//  RESP (1 cycle)
//   - resp_valid[id] = 1; resp_rdata = captured data (write: 0).
//   - Then go to IDLE.
//  Timing
//   - Accept in cycle A.
//   - Write: MemWrite in A+1, resp in A+2.
//   - Read: MemRead in A+1, resp in A+2+READ_LATENCY.
//  Requester obligations
//   - Hold valid/write/addr/wdata stable until ready.
//   - req_valid may stay high across the RESP cycle; the next accept is in IDLE at the earliest.
//  Memory controls
//   - MemRead and MemWrite are never both 1.
//   - Each is high for exactly one cycle per request.
//   - Address and writeData hold their last value between requests.
//  Boundary conditions
//   - A lone requester is granted every IDLE cycle it is valid, regardless of last_grant.
//   - Under continuous contention, grants alternate strictly 0,1,0,1,...
//   - reset in any state: next cycle FSM = IDLE, all outputs 0, last_grant = 1.
//     Any in-flight request is dropped and no resp_valid is issued for it.
//   - Requests to the same address from both ports are serialized in grant order.
//     A read that follows a write returns the written data.
// TESTING
//  1. Port 0 write 0x04<-0x2, then read 0x04 (READ_LATENCY=1).
//     -> write resp at A+2 with resp_rdata=0; read resp_valid=2'b01, resp_rdata=0x2 at A+3.
//  2. Both ports valid reading 0x08 / 0x0C (preloaded 0x5 / 0x9), held continuously.
//     -> grants 0,1,0,1; resp_valid alternates 01/10 with 0x5 / 0x9.
//  3. Only port 1 valid, back-to-back reads of 0x18 and 0x1C (0x7 / 0xA).
//     -> port 1 granted each IDLE; both responses arrive, 4 cycles per read.
//  4. READ_LATENCY=3, port 1 reads 0x1C holding 0xA.
//     -> MemRead high only at A+1; resp_valid=2'b10 with 0xA at A+5.
//  5. reset pulsed during WAIT of a port 0 read.
//     -> no resp_valid, MemRead=0; afterwards contention grants port 0 first.
//  6. Port 1 write 0x18<-0x7.
//     -> exactly 1 cycle of MemWrite=1, Address=0x18, writeData=0x7; MemRead stays 0.

Source files
------------

// File: rtl/memory_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : memory_arbiter_if                                    |
// | Description : Requester-side handshake plus Memory-side bus of the |
// |               two-port memory arbiter, bundled into one interface. |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
interface memory_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // Requester side (port 0 = instruction fetch, port 1 = data load/store)
  logic [1:0]            req_valid;
  logic [1:0]            req_write;
  logic [ADDR_WIDTH-1:0] req_addr0;
  logic [ADDR_WIDTH-1:0] req_addr1;
  logic [DATA_WIDTH-1:0] req_wdata0;
  logic [DATA_WIDTH-1:0] req_wdata1;
  logic [1:0]            req_ready;
  logic [1:0]            resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;

  // Memory side
  logic                  MemRead;
  logic                  MemWrite;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] writeData;
  logic [DATA_WIDTH-1:0] ReadData;

  // Arbiter view: receives requests and read data, drives responses and Memory controls
  modport slave (
    input  req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  ReadData,
    output req_ready, resp_valid, resp_rdata,
    output MemRead, MemWrite, Address, writeData
  );

  // Environment view: requesters plus the Memory block
  modport master (
    output req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output ReadData,
    input  req_ready, resp_valid, resp_rdata,
    input  MemRead, MemWrite, Address, writeData
  );
endinterface
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : memory_arbiter                                       |
// | Description : Two-requester round-robin arbiter/sequencer in front |
// |               of a single-port Memory. One access in flight; read  |
// |               data or a write acknowledge returns to the issuer.   |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module memory_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1    // legal range 1..15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  memory_arbiter_if.slave   bus
);

  localparam int              CNT_W      = 4;
  localparam logic [CNT_W-1:0] C_LAT_LOAD = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                state_q;
  logic                  last_grant_q;   // port granted most recently
  logic                  port_q;         // port owning the in-flight access
  logic                  write_q;        // in-flight access is a write
  logic [CNT_W-1:0]      cnt_q;          // remaining read-latency cycles
  logic [1:0]            resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [1:0]            grant_d;
  logic                  sel_write_d;
  logic [ADDR_WIDTH-1:0] sel_addr_d;
  logic [DATA_WIDTH-1:0] sel_wdata_d;

  // Round-robin grant: a lone requester always wins; on contention the
  // port that did not win last time is chosen. Only offered in IDLE.
  always_comb begin
    grant_d = 2'b00;
    if (state_q == ST_IDLE) begin
      case (bus.req_valid)
        2'b01:   grant_d = 2'b01;
        2'b10:   grant_d = 2'b10;
        2'b11:   grant_d = last_grant_q ? 2'b01 : 2'b10;
        default: grant_d = 2'b00;
      endcase
    end
  end

  // Request fields of the granted port, latched on accept
  always_comb begin
    sel_write_d = grant_d[1] ? bus.req_write[1] : bus.req_write[0];
    sel_addr_d  = grant_d[1] ? bus.req_addr1    : bus.req_addr0;
    sel_wdata_d = grant_d[1] ? bus.req_wdata1   : bus.req_wdata0;
  end

  // Sequencer FSM with registered Memory controls and response outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      write_q      <= 1'b0;
      cnt_q        <= '0;
      resp_valid_q <= 2'b00;
      resp_rdata_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_d != 2'b00) begin
            port_q       <= grant_d[1];
            last_grant_q <= grant_d[1];
            write_q      <= sel_write_d;
            addr_q       <= sel_addr_d;
            wdata_q      <= sel_wdata_d;
            mem_write_q  <= sel_write_d;
            mem_read_q   <= ~sel_write_d;
            state_q      <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          // Strobes last exactly one cycle; Address/writeData keep their value
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          if (write_q) begin
            resp_valid_q <= {port_q, ~port_q};
            resp_rdata_q <= '0;
            state_q      <= ST_RESP;
          end else begin
            cnt_q   <= C_LAT_LOAD;
            state_q <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (cnt_q == '0) begin
            resp_rdata_q <= bus.ReadData;
            resp_valid_q <= {port_q, ~port_q};
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_RESP: begin
          resp_valid_q <= 2'b00;
          state_q      <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = grant_d;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.MemRead    = mem_read_q;
  assign bus.MemWrite   = mem_write_q;
  assign bus.Address    = addr_q;
  assign bus.writeData  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_memory_arbiter                                    |
// | Description : Self-checking bench for memory_arbiter. Two DUTs     |
// |               (READ_LATENCY 1 and 3), each with a Memory model and |
// |               a reference model feeding a response scoreboard.     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_memory_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int RL0 = 1;
  localparam int RL1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  memory_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa ();
  memory_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb ();

  memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL0)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifa)
  );

  memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL1)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifb)
  );

  function automatic logic [31:0] init_val(input int i);
    case (i)
      2:       return 32'h5;
      3:       return 32'h9;
      6:       return 32'h7;
      7:       return 32'hA;
      default: return 32'h1000_0000 + 32'(i);
    endcase
  endfunction

  function automatic int rl_of(input int d);
    return (d == 0) ? RL0 : RL1;
  endfunction

  // Memory models: read data valid only in cycle MemRead+READ_LATENCY
  logic [31:0] dev0 [0:63];
  logic [31:0] dev1 [0:63];
  int          rc0, rc1;
  logic [5:0]  ra0, ra1;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) dev0[i] <= init_val(i);
      rc0 <= 0;
      ra0 <= '0;
    end else begin
      if (ifa.MemWrite) dev0[ifa.Address[7:2]] <= ifa.writeData;
      if (ifa.MemRead) begin
        rc0 <= 1;
        ra0 <= ifa.Address[7:2];
      end else if (rc0 != 0 && rc0 < RL0) rc0 <= rc0 + 1;
      else rc0 <= 0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) dev1[i] <= init_val(i);
      rc1 <= 0;
      ra1 <= '0;
    end else begin
      if (ifb.MemWrite) dev1[ifb.Address[7:2]] <= ifb.writeData;
      if (ifb.MemRead) begin
        rc1 <= 1;
        ra1 <= ifb.Address[7:2];
      end else if (rc1 != 0 && rc1 < RL1) rc1 <= rc1 + 1;
      else rc1 <= 0;
    end
  end

  assign ifa.ReadData = (rc0 == RL0) ? dev0[ra0] : 32'hDEAD_BEEF;
  assign ifb.ReadData = (rc1 == RL1) ? dev1[ra1] : 32'hDEAD_BEEF;

  // Scoreboard and reference-model state
  typedef struct {
    int          d;
    int          port;
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [$];
  int          idle_at   [2];
  int          issue_cyc [2];
  logic        last_g    [2];
  logic        issue_w   [2];
  logic [31:0] issue_a   [2];
  logic [31:0] issue_d   [2];
  logic [31:0] refmem    [2][0:63];
  int          gport [$];   // DUT A observed grants
  int          gcyc  [$];
  logic        prev_rst = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string tag);
    compared++;
    mismatched++;
    $error("FAIL %s: timed out waiting for DUT (cycle %0d)", tag, cyc);
  endtask

  task automatic zero_chk(input int d, input logic [1:0] rv, input logic [31:0] rdat,
                          input logic mr, input logic mw, input logic [31:0] addr,
                          input logic [31:0] wdat);
    chk($sformatf("d%0d_rst_resp_valid", d), 32'(rv), 32'h0);
    chk($sformatf("d%0d_rst_resp_rdata", d), rdat, 32'h0);
    chk($sformatf("d%0d_rst_MemRead", d), 32'(mr), 32'h0);
    chk($sformatf("d%0d_rst_MemWrite", d), 32'(mw), 32'h0);
    chk($sformatf("d%0d_rst_Address", d), addr, 32'h0);
    chk($sformatf("d%0d_rst_writeData", d), wdat, 32'h0);
  endtask

  task automatic mon(input int d, input logic [1:0] v, input logic [1:0] w,
                     input logic [1:0] rdy, input logic [1:0] rv,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] wd0, input logic [31:0] wd1,
                     input logic [31:0] rdat, input logic [31:0] addr,
                     input logic [31:0] wdat, input logic mr, input logic mw);
    logic [1:0]  er;
    logic [1:0]  ev;
    logic [1:0]  acc;
    logic [1:0]  hs;
    int          idx;
    int          p;
    logic        wr;
    logic [31:0] ad;
    logic [31:0] dt;
    exp_t        e;

    er = 2'b00;
    if (cyc >= idle_at[d]) begin
      if (v == 2'b11) er = last_g[d] ? 2'b01 : 2'b10;
      else            er = v;
    end
    chk($sformatf("d%0d_req_ready", d), 32'(rdy), 32'(er));

    chk($sformatf("d%0d_MemRead", d), 32'(mr), 32'(cyc == issue_cyc[d] && !issue_w[d]));
    chk($sformatf("d%0d_MemWrite", d), 32'(mw), 32'(cyc == issue_cyc[d] && issue_w[d]));
    if (cyc == issue_cyc[d]) begin
      chk($sformatf("d%0d_Address", d), addr, issue_a[d]);
      if (issue_w[d]) chk($sformatf("d%0d_writeData", d), wdat, issue_d[d]);
    end

    idx = -1;
    foreach (sb[i]) if (idx < 0 && sb[i].d == d) idx = i;
    ev = 2'b00;
    if (idx >= 0 && sb[idx].cyc == cyc) ev = (sb[idx].port == 1) ? 2'b10 : 2'b01;
    chk($sformatf("d%0d_resp_valid", d), 32'(rv), 32'(ev));
    if (ev != 2'b00) begin
      chk($sformatf("d%0d_resp_rdata", d), rdat, sb[idx].data);
      sb.delete(idx);
    end

    hs = v & rdy;
    if (d == 0 && hs != 2'b00) begin
      gport.push_back(hs[1] ? 1 : 0);
      gcyc.push_back(cyc);
    end

    acc = v & er;
    if (acc != 2'b00) begin
      p  = acc[1] ? 1 : 0;
      wr = w[p];
      ad = (p == 1) ? a1 : a0;
      dt = (p == 1) ? wd1 : wd0;
      last_g[d]    = (p == 1);
      issue_cyc[d] = cyc + 1;
      issue_w[d]   = wr;
      issue_a[d]   = ad;
      issue_d[d]   = dt;
      e.d    = d;
      e.port = p;
      if (wr) begin
        e.cyc  = cyc + 2;
        e.data = 32'h0;
        refmem[d][ad[7:2]] = dt;
        idle_at[d] = cyc + 3;
      end else begin
        e.cyc  = cyc + 2 + rl_of(d);
        e.data = refmem[d][ad[7:2]];
        idle_at[d] = cyc + 3 + rl_of(d);
      end
      sb.push_back(e);
    end
  endtask

  // Checker process: sample DUT outputs on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      for (int d = 0; d < 2; d++) begin
        idle_at[d]   = cyc + 1;
        issue_cyc[d] = -1;
        last_g[d]    = 1'b1;
        issue_w[d]   = 1'b0;
        issue_a[d]   = '0;
        issue_d[d]   = '0;
        for (int i = 0; i < 64; i++) refmem[d][i] = init_val(i);
      end
      prev_rst = 1'b1;
    end else begin
      if (prev_rst) begin
        zero_chk(0, ifa.resp_valid, ifa.resp_rdata, ifa.MemRead, ifa.MemWrite,
                 ifa.Address, ifa.writeData);
        zero_chk(1, ifb.resp_valid, ifb.resp_rdata, ifb.MemRead, ifb.MemWrite,
                 ifb.Address, ifb.writeData);
      end
      mon(0, ifa.req_valid, ifa.req_write, ifa.req_ready, ifa.resp_valid,
          ifa.req_addr0, ifa.req_addr1, ifa.req_wdata0, ifa.req_wdata1,
          ifa.resp_rdata, ifa.Address, ifa.writeData, ifa.MemRead, ifa.MemWrite);
      mon(1, ifb.req_valid, ifb.req_write, ifb.req_ready, ifb.resp_valid,
          ifb.req_addr0, ifb.req_addr1, ifb.req_wdata0, ifb.req_wdata1,
          ifb.resp_rdata, ifb.Address, ifb.writeData, ifb.MemRead, ifb.MemWrite);
      prev_rst = 1'b0;
    end
  end

  // Single request on DUT A: drive, wait for accept, release valid
  task automatic req_a(input int p, input logic w, input logic [31:0] a, input logic [31:0] dat);
    bit ok;
    @(posedge clk); #1;
    ifa.req_write[p] = w;
    if (p == 1) begin
      ifa.req_addr1  = a;
      ifa.req_wdata1 = dat;
    end else begin
      ifa.req_addr0  = a;
      ifa.req_wdata0 = dat;
    end
    ifa.req_valid[p] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (ifa.req_ready[p]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("req_a_accept");
    @(posedge clk); #1;
    ifa.req_valid[p] = 1'b0;
  endtask

  task automatic wait_grants(input int target);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (gport.size() >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeout_fail("wait_grants");
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n0;
    bit  ok;
    ifa.req_valid  = 2'b00;  ifa.req_write  = 2'b00;
    ifa.req_addr0  = '0;     ifa.req_addr1  = '0;
    ifa.req_wdata0 = '0;     ifa.req_wdata1 = '0;
    ifb.req_valid  = 2'b00;  ifb.req_write  = 2'b00;
    ifb.req_addr0  = '0;     ifb.req_addr1  = '0;
    ifb.req_wdata0 = '0;     ifb.req_wdata1 = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Port 0 write 0x04 <- 0x2, then read it back
    req_a(0, 1'b1, 32'h04, 32'h2);
    req_a(0, 1'b0, 32'h04, 32'h0);
    drain();

    // Port 1 write 0x18 <- 0x7 (leaves last grant on port 1)
    req_a(1, 1'b1, 32'h18, 32'h7);
    drain();

    // Continuous contention: grants must alternate 0,1,0,1
    n0 = gport.size();
    @(posedge clk); #1;
    ifa.req_addr0 = 32'h08;
    ifa.req_addr1 = 32'h0C;
    ifa.req_write = 2'b00;
    ifa.req_valid = 2'b11;
    wait_grants(n0 + 4);
    @(posedge clk); #1;
    ifa.req_valid = 2'b00;
    if (gport.size() >= n0 + 4)
      for (int i = 0; i < 4; i++) chk("t2_grant_order", 32'(gport[n0 + i]), 32'(i % 2));
    drain();

    // Lone port 1, back-to-back reads of 0x18 then 0x1C
    n0 = gport.size();
    @(posedge clk); #1;
    ifa.req_addr1    = 32'h18;
    ifa.req_write[1] = 1'b0;
    ifa.req_valid[1] = 1'b1;
    wait_grants(n0 + 1);
    @(posedge clk); #1;
    ifa.req_addr1 = 32'h1C;
    wait_grants(n0 + 2);
    @(posedge clk); #1;
    ifa.req_valid[1] = 1'b0;
    if (gport.size() >= n0 + 2) begin
      chk("t3_grant_first", 32'(gport[n0]), 32'd1);
      chk("t3_grant_second", 32'(gport[n0 + 1]), 32'd1);
      chk("t3_read_spacing", 32'(gcyc[n0 + 1] - gcyc[n0]), 32'd4);
    end
    drain();

    // READ_LATENCY=3 DUT: port 1 reads 0x1C
    @(posedge clk); #1;
    ifb.req_addr1    = 32'h1C;
    ifb.req_write[1] = 1'b0;
    ifb.req_valid[1] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (ifb.req_ready[1]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("t4_accept");
    @(posedge clk); #1;
    ifb.req_valid[1] = 1'b0;
    drain();

    // Reset during WAIT of a port 0 read: response is dropped
    req_a(0, 1'b0, 32'h08, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n0 = gport.size();
    ifa.req_addr0 = 32'h08;
    ifa.req_addr1 = 32'h0C;
    ifa.req_write = 2'b00;
    ifa.req_valid = 2'b11;
    @(negedge clk);
    chk("t5_first_grant", 32'(ifa.req_ready), 32'h1);
    wait_grants(n0 + 2);
    @(posedge clk); #1;
    ifa.req_valid = 2'b00;
    if (gport.size() >= n0 + 2) begin
      chk("t5_grant0", 32'(gport[n0]), 32'd0);
      chk("t5_grant1", 32'(gport[n0 + 1]), 32'd1);
    end
    drain();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
